// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl
//   Hazard and forwarding control for a 5-stage pipeline. It keeps a shadow
//   copy of the EX, MEM and WB stage information, built from the ID-stage
//   decode fields. From that copy it produces:
//   - the load-use stall (PC and IF/ID hold, plus a bubble into ID/EX);
//   - the EX-stage forwarding selects;
//   - saturating performance counters for stall cycles and flush cycles.
//
// Ports
//   Clk          in   rising-edge clock
//   Rst          in   asynchronous active-low reset
//   IDRs/IDRt/IDRd  in  [4:0]  register fields of the instruction in ID
//   IDRegDst     in   1: destination is rd, 0: destination is rt
//   IDRegWrite   in   ID instruction writes the register file
//   IDMemRead    in   ID instruction is a load
//   IDUsesRt     in   rt is a source operand
//   PCSrc        in   branch taken, resolved in MEM; flushes EX and MEM
//   PCWrite      out  0 holds the PC
//   IF_ID_Write  out  0 holds the IF/ID register
//   controlMux   out  1 zeroes the ID control (bubble into ID/EX)
//   MuxA/MuxB    out  [1:0] forwarding select: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   StallCount   out  [CNT_W-1:0] load-use stall cycles since reset
//   FlushCount   out  [CNT_W-1:0] PCSrc cycles since reset

module hazard_forward_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       IDRs,
  input  logic [4:0]       IDRt,
  input  logic [4:0]       IDRd,
  input  logic             IDRegDst,
  input  logic             IDRegWrite,
  input  logic             IDMemRead,
  input  logic             IDUsesRt,
  input  logic             PCSrc,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             controlMux,
  output logic [1:0]       MuxA,
  output logic [1:0]       MuxB,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // EX slot keeps everything that the hazard and forwarding checks read.
  // MEM and WB keep only the fields that are looked at later.
  logic       ex_valid_q, ex_valid_d;
  logic [4:0] ex_rs_q, ex_rs_d;
  logic [4:0] ex_rt_q, ex_rt_d;
  logic       ex_uses_rt_q, ex_uses_rt_d;
  logic [4:0] ex_dest_q, ex_dest_d;
  logic       ex_reg_write_q, ex_reg_write_d;
  logic       ex_mem_read_q, ex_mem_read_d;

  logic [4:0] mem_dest_q, mem_dest_d;
  logic       mem_reg_write_q, mem_reg_write_d;
  logic       mem_mem_read_q, mem_mem_read_d;

  logic [4:0] wb_dest_q, wb_dest_d;
  logic       wb_reg_write_q, wb_reg_write_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [4:0] id_dest;
  logic       stall;
  logic       mem_fwd_ok;
  logic       wb_fwd_ok;

  assign id_dest = IDRegDst ? IDRd : IDRt;

  // A taken branch squashes the consumer too, so it overrides the stall.
  always_comb begin
    stall = 1'b0;
    if (!PCSrc && ex_valid_q && ex_mem_read_q && (ex_dest_q != 5'd0)) begin
      if ((ex_dest_q == IDRs) || (IDUsesRt && (ex_dest_q == IDRt))) begin
        stall = 1'b1;
      end
    end
  end

  assign PCWrite     = !stall;
  assign IF_ID_Write = !stall;
  assign controlMux  = stall;

  // A load result is not available in EX/MEM; it can only forward from WB.
  assign mem_fwd_ok = mem_reg_write_q && !mem_mem_read_q && (mem_dest_q != 5'd0);
  assign wb_fwd_ok  = wb_reg_write_q && (wb_dest_q != 5'd0);

  always_comb begin
    MuxA = SEL_RF;
    if (mem_fwd_ok && (mem_dest_q == ex_rs_q)) begin
      MuxA = SEL_MEM;
    end else if (wb_fwd_ok && (wb_dest_q == ex_rs_q)) begin
      MuxA = SEL_WB;
    end
  end

  always_comb begin
    MuxB = SEL_RF;
    if (ex_uses_rt_q) begin
      if (mem_fwd_ok && (mem_dest_q == ex_rt_q)) begin
        MuxB = SEL_MEM;
      end else if (wb_fwd_ok && (wb_dest_q == ex_rt_q)) begin
        MuxB = SEL_WB;
      end
    end
  end

  always_comb begin
    ex_valid_d     = 1'b1;
    ex_rs_d        = IDRs;
    ex_rt_d        = IDRt;
    ex_uses_rt_d   = IDUsesRt;
    ex_dest_d      = id_dest;
    ex_reg_write_d = IDRegWrite;
    ex_mem_read_d  = IDMemRead;
    if (stall || PCSrc) begin
      ex_valid_d     = 1'b0;
      ex_rs_d        = 5'd0;
      ex_rt_d        = 5'd0;
      ex_uses_rt_d   = 1'b0;
      ex_dest_d      = 5'd0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
    end

    mem_dest_d      = ex_dest_q;
    mem_reg_write_d = ex_reg_write_q;
    mem_mem_read_d  = ex_mem_read_q;
    if (PCSrc) begin
      mem_dest_d      = 5'd0;
      mem_reg_write_d = 1'b0;
      mem_mem_read_d  = 1'b0;
    end

    wb_dest_d      = mem_dest_q;
    wb_reg_write_d = mem_reg_write_q;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    flush_cnt_d = flush_cnt_q;
    if (PCSrc && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ex_valid_q      <= 1'b0;
      ex_rs_q         <= 5'd0;
      ex_rt_q         <= 5'd0;
      ex_uses_rt_q    <= 1'b0;
      ex_dest_q       <= 5'd0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      mem_dest_q      <= 5'd0;
      mem_reg_write_q <= 1'b0;
      mem_mem_read_q  <= 1'b0;
      wb_dest_q       <= 5'd0;
      wb_reg_write_q  <= 1'b0;
      stall_cnt_q     <= '0;
      flush_cnt_q     <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_rs_q         <= ex_rs_d;
      ex_rt_q         <= ex_rt_d;
      ex_uses_rt_q    <= ex_uses_rt_d;
      ex_dest_q       <= ex_dest_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      mem_dest_q      <= mem_dest_d;
      mem_reg_write_q <= mem_reg_write_d;
      mem_mem_read_q  <= mem_mem_read_d;
      wb_dest_q       <= wb_dest_d;
      wb_reg_write_q  <= wb_reg_write_d;
      stall_cnt_q     <= stall_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
module tb_hazard_forward_ctrl;

  logic        Clk;
  logic        Rst;
  logic [4:0]  IDRs, IDRt, IDRd;
  logic        IDRegDst, IDRegWrite, IDMemRead, IDUsesRt, PCSrc;

  logic        PCWrite, IF_ID_Write, controlMux;
  logic [1:0]  MuxA, MuxB;
  logic [15:0] StallCount, FlushCount;

  logic        nr_PCWrite, nr_IF_ID_Write, nr_controlMux;
  logic [1:0]  nr_MuxA, nr_MuxB;
  logic [1:0]  nr_StallCount, nr_FlushCount;

  int n_assert = 0;
  int n_fail   = 0;

  hazard_forward_ctrl #(.CNT_W(16)) u_dut (
    .Clk(Clk), .Rst(Rst), .IDRs(IDRs), .IDRt(IDRt), .IDRd(IDRd),
    .IDRegDst(IDRegDst), .IDRegWrite(IDRegWrite), .IDMemRead(IDMemRead),
    .IDUsesRt(IDUsesRt), .PCSrc(PCSrc), .PCWrite(PCWrite),
    .IF_ID_Write(IF_ID_Write), .controlMux(controlMux), .MuxA(MuxA),
    .MuxB(MuxB), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  hazard_forward_ctrl #(.CNT_W(2)) u_dut_narrow (
    .Clk(Clk), .Rst(Rst), .IDRs(IDRs), .IDRt(IDRt), .IDRd(IDRd),
    .IDRegDst(IDRegDst), .IDRegWrite(IDRegWrite), .IDMemRead(IDMemRead),
    .IDUsesRt(IDUsesRt), .PCSrc(PCSrc), .PCWrite(nr_PCWrite),
    .IF_ID_Write(nr_IF_ID_Write), .controlMux(nr_controlMux), .MuxA(nr_MuxA),
    .MuxB(nr_MuxB), .StallCount(nr_StallCount), .FlushCount(nr_FlushCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic regdst, input logic rw, input logic mr, input logic uses);
    IDRs = rs; IDRt = rt; IDRd = rd;
    IDRegDst = regdst; IDRegWrite = rw; IDMemRead = mr; IDUsesRt = uses;
    #1;
  endtask

  task automatic nop();
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_hz(input string tag, input logic exp_stall);
    chk({tag, "_pcw"},  {31'd0, PCWrite},     {31'd0, !exp_stall});
    chk({tag, "_ifid"}, {31'd0, IF_ID_Write}, {31'd0, !exp_stall});
    chk({tag, "_cmux"}, {31'd0, controlMux},  {31'd0, exp_stall});
  endtask

  task automatic chk_mux(input string tag, input logic [1:0] a, input logic [1:0] b);
    chk({tag, "_muxa"}, {30'd0, MuxA}, {30'd0, a});
    chk({tag, "_muxb"}, {30'd0, MuxB}, {30'd0, b});
  endtask

  // lw $2,0($1) followed by add $4,$2,$2, leaving the add in EX
  task automatic load_use_pair();
    set_id(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(5'd2, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
  endtask

  initial begin
    Rst = 1'b0; PCSrc = 1'b0;
    nop();
    #1;
    chk_hz("rst", 1'b0);
    chk_mux("rst", 2'b00, 2'b00);
    chk("rst_stallcnt", {16'd0, StallCount}, 32'd0);
    chk("rst_flushcnt", {16'd0, FlushCount}, 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    tick();

    // T2: add $3,$1,$2 ; sub $4,$3,$5
    set_id(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    chk_hz("t2_add_id", 1'b0);
    tick();
    set_id(5'd3, 5'd5, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    chk_hz("t2_sub_id", 1'b0);
    tick();
    chk_mux("t2_sub_ex", 2'b01, 2'b00);

    // T3: add $3 ; nop ; or $6,$3,$3
    set_id(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    nop();
    tick();
    set_id(5'd3, 5'd3, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk_mux("t3_or_ex", 2'b10, 2'b10);

    // both MEM and WB write $3: the younger (MEM) wins
    set_id(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_id(5'd7, 5'd8, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_id(5'd3, 5'd3, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk_mux("t3_mem_beats_wb", 2'b01, 2'b01);

    // rt not a source: addi $3,$1,imm after a write to $3
    set_id(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_id(5'd1, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_mux("t3_uses_rt_off", 2'b00, 2'b00);

    // $0 never forwards
    set_id(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_id(5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk_mux("t3_reg0", 2'b00, 2'b00);

    // a load to $0 never stalls
    set_id(5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    chk_hz("t3_lw_reg0", 1'b0);
    nop(); tick(); tick(); tick();

    // T4: lw $2,0($1) ; add $4,$2,$2
    set_id(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_hz("t4_lw_id", 1'b0);
    tick();
    set_id(5'd2, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    chk_hz("t4_stall", 1'b1);
    chk("t4_cnt_before", {16'd0, StallCount}, 32'd0);
    tick();
    chk_hz("t4_after_stall", 1'b0);
    chk("t4_stallcnt", {16'd0, StallCount}, 32'd1);
    chk("t4_nr_stallcnt", {30'd0, nr_StallCount}, 32'd1);
    tick();
    chk_mux("t4_add_ex", 2'b10, 2'b10);
    nop(); tick(); tick(); tick();

    // T5: load-use with PCSrc in the same cycle
    set_id(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(5'd2, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    PCSrc = 1'b1;
    #1;
    chk_hz("t5_flush", 1'b0);
    chk("t5_flush_before", {16'd0, FlushCount}, 32'd0);
    tick();
    PCSrc = 1'b0;
    #1;
    chk("t5_flushcnt", {16'd0, FlushCount}, 32'd1);
    chk("t5_stallcnt", {16'd0, StallCount}, 32'd1);
    chk_hz("t5_refetch_id", 1'b0);
    tick();
    chk_mux("t5_add_ex", 2'b00, 2'b00);

    // T6: five more load-use pairs
    for (int i = 0; i < 5; i++) load_use_pair();
    chk("t6_nr_sat", {30'd0, nr_StallCount}, 32'd3);
    chk("t6_wide_cnt", {16'd0, StallCount}, 32'd6);
    chk("t6_nr_flushcnt", {30'd0, nr_FlushCount}, 32'd1);
    nop(); tick(); tick(); tick();

    // T1: asynchronous reset in the middle of a stall
    set_id(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(5'd2, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    chk_hz("t1_pre_stall", 1'b1);
    Rst = 1'b0;
    #1;
    chk_hz("t1_rst", 1'b0);
    chk_mux("t1_rst", 2'b00, 2'b00);
    chk("t1_stallcnt", {16'd0, StallCount}, 32'd0);
    chk("t1_flushcnt", {16'd0, FlushCount}, 32'd0);
    chk("t1_nr_stallcnt", {30'd0, nr_StallCount}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
